// File: rtl/flag_write_arbiter.sv
// flag_write_arbiter
//   Round-robin write-side arbiter for a single-bit flag storage element
//   shared by NUM_REQ requesters. One owner at a time; an owner may keep
//   ownership with Lock for at most MAX_HOLD consecutive cycles.
//
// Ports
//   Clk          clock, rising edge
//   Reset        asynchronous active-low reset
//   Req[N]       per-requester write request (level)
//   Lock[N]      per-requester request to keep ownership past this cycle
//   BitVal[N]    per-requester write data
//   Grant[N]     one-hot owner, registered (0 when idle)
//   GrantIdx     owner index, 0 when idle
//   WriteEn      write strobe to the flag storage
//   BitValIn     write data to the flag storage (0 when not writing)
//   Busy         high while a requester owns the storage
//   HoldExpired  high in the cycle a lock is cut off by MAX_HOLD
module flag_write_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_REQ-1:0] Req,
  input  logic [NUM_REQ-1:0] Lock,
  input  logic [NUM_REQ-1:0] BitVal,
  output logic [NUM_REQ-1:0] Grant,
  output logic [IW-1:0]      GrantIdx,
  output logic               WriteEn,
  output logic               BitValIn,
  output logic               Busy,
  output logic               HoldExpired
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {S_IDLE, S_OWNED} state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IW-1:0]      r_gidx;
  logic [IW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;

  logic          w_owned;
  logic          w_own_req;
  logic          w_own_lock;
  logic          w_at_max;
  logic          w_keep;
  logic [IW-1:0] w_nptr;
  logic [IW-1:0] w_arb_ptr;
  logic          w_win_vld;
  logic [IW-1:0] w_win_idx;

  // (p + k) mod NUM_REQ without a real divider; p < NUM_REQ and k < NUM_REQ.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  assign w_owned    = (r_state == S_OWNED);
  assign w_own_req  = w_owned & Req[r_gidx];
  assign w_own_lock = Lock[r_gidx];
  assign w_at_max   = (r_cnt == CW'(MAX_HOLD));
  assign w_keep     = w_own_req & w_own_lock & ~w_at_max;

  assign w_nptr     = (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + IW'(1);

  // On release the search already starts from the advanced pointer, so the
  // next owner is picked in the same cycle (no idle bubble) and the old
  // owner only wins again when nobody else is asking.
  assign w_arb_ptr  = w_owned ? w_nptr : r_ptr;

  // Scan from the far end back to the pointer so the closest requester
  // (smallest offset) is the last assignment and wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (Req[wrap_add(w_arb_ptr, k)]) begin
        w_win_vld = 1'b1;
        w_win_idx = wrap_add(w_arb_ptr, k);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            r_state <= S_OWNED;
            r_grant <= NUM_REQ'(1) << w_win_idx;
            r_gidx  <= w_win_idx;
            r_cnt   <= CW'(1);
          end
        end
        S_OWNED: begin
          if (w_keep) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_ptr <= w_nptr;
            if (w_win_vld) begin
              r_grant <= NUM_REQ'(1) << w_win_idx;
              r_gidx  <= w_win_idx;
              r_cnt   <= CW'(1);
            end else begin
              r_state <= S_IDLE;
              r_grant <= '0;
              r_gidx  <= '0;
              r_cnt   <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Grant       = r_grant;
  assign GrantIdx    = r_gidx;
  assign Busy        = w_owned;
  // An owner that dropped Req does not write in that cycle.
  assign WriteEn     = w_own_req;
  assign BitValIn    = w_own_req & BitVal[r_gidx];
  // The cut-off cycle still performs its write.
  assign HoldExpired = w_own_req & w_own_lock & w_at_max;

endmodule

// File: tb/tb_flag_write_arbiter.sv
module tb_flag_write_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] Req, Lock, BitVal;
  wire  [3:0] Grant;
  wire  [1:0] GrantIdx;
  wire        WriteEn, BitValIn, Busy, HoldExpired;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic flag    = 1'b0;   // models the shared flag storage

  typedef struct {
    string      nm;
    logic [9:0] v;        // {Grant, GrantIdx, WriteEn, BitValIn, Busy, HoldExpired}
  } exp_t;

  exp_t sb[$];

  flag_write_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Lock(Lock), .BitVal(BitVal),
    .Grant(Grant), .GrantIdx(GrantIdx), .WriteEn(WriteEn), .BitValIn(BitValIn),
    .Busy(Busy), .HoldExpired(HoldExpired)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (WriteEn) flag <= BitValIn;

  wire [9:0] obs = {Grant, GrantIdx, WriteEn, BitValIn, Busy, HoldExpired};

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // f = {WriteEn, BitValIn, Busy, HoldExpired}
  task automatic push_exp(input string nm, input logic [3:0] g, input logic [1:0] i, input logic [3:0] f);
    exp_t t;
    t.nm = nm;
    t.v  = {g, i, f};
    sb.push_back(t);
  endtask

  task automatic do_reset();
    Reset = 1'b0; Req = '0; Lock = '0; BitVal = '0;
    step();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t t;
    Reset = 1'b0; Req = 4'b1111; Lock = '0; BitVal = '0;
    push_exp("rst_async", 4'b0000, 2'd0, 4'b0000);
    #2;
    t = sb.pop_front(); n_tests++;
    if (obs !== t.v) begin n_fail++; $display("FAIL %s: got %b expected %b", t.nm, obs, t.v); end
    step();
    push_exp("rst_held", 4'b0000, 2'd0, 4'b0000);
    t = sb.pop_front(); n_tests++;
    if (obs !== t.v) begin n_fail++; $display("FAIL %s: got %b expected %b", t.nm, obs, t.v); end
    Reset = 1'b1;
    push_exp("rst_first_grant", 4'b0001, 2'd0, 4'b1010);
    step();
    t = sb.pop_front(); n_tests++;
    if (obs !== t.v) begin n_fail++; $display("FAIL %s: got %b expected %b", t.nm, obs, t.v); end
    Req = '0;
  endtask

  task automatic test_single_write();
    exp_t t;
    logic [3:0] eg [0:3];
    logic [3:0] ef [0:3];
    eg = '{4'b0000, 4'b0001, 4'b0001, 4'b0000};
    ef = '{4'b0000, 4'b1110, 4'b0010, 4'b0000};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step();
      Req = (c < 2) ? 4'b0001 : 4'b0000; Lock = '0; BitVal = 4'b0001;
      push_exp($sformatf("single_c%0d", c), eg[c], 2'd0, ef[c]);
      #1;
      t = sb.pop_front(); n_tests++;
      if (obs !== t.v) begin n_fail++; $display("FAIL %s: got %b expected %b", t.nm, obs, t.v); end
      if (c >= 2) begin
        n_tests++;
        if (flag !== 1'b1) begin n_fail++; $display("FAIL single_flag_c%0d: got %b expected 1", c, flag); end
      end
    end
    Req = '0;
  endtask

  task automatic test_round_robin();
    exp_t t;
    logic [3:0] eg [0:5];
    logic [1:0] ei [0:5];
    logic [3:0] ef [0:5];
    eg = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ei = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ef = '{4'b0000, 4'b1010, 4'b1110, 4'b1010, 4'b1110, 4'b1010};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step();
      Req = 4'b1111; Lock = '0; BitVal = 4'b1010;
      push_exp($sformatf("rr_c%0d", c), eg[c], ei[c], ef[c]);
      #1;
      t = sb.pop_front(); n_tests++;
      if (obs !== t.v) begin n_fail++; $display("FAIL %s: got %b expected %b", t.nm, obs, t.v); end
    end
    Req = '0;
  endtask

  task automatic test_hold_expire();
    exp_t t;
    logic [3:0] g, f;
    logic [1:0] i;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      Req = (c >= 3) ? 4'b0101 : 4'b0100; Lock = 4'b0100; BitVal = 4'b0100;
      if (c == 0)      begin g = 4'b0000; i = 2'd0; f = 4'b0000; end
      else if (c < 8)  begin g = 4'b0100; i = 2'd2; f = 4'b1110; end
      else if (c == 8) begin g = 4'b0100; i = 2'd2; f = 4'b1111; end
      else             begin g = 4'b0001; i = 2'd0; f = 4'b1010; end
      push_exp($sformatf("hold_c%0d", c), g, i, f);
      #1;
      t = sb.pop_front(); n_tests++;
      if (obs !== t.v) begin n_fail++; $display("FAIL %s: got %b expected %b", t.nm, obs, t.v); end
    end
    Req = '0; Lock = '0;
  endtask

  task automatic test_reset_mid_lock();
    exp_t t;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step();
      Req = 4'b0010; Lock = 4'b0010; BitVal = (c == 4) ? 4'b0010 : 4'b0000;
      if (c == 0)      push_exp("midrst_c0", 4'b0000, 2'd0, 4'b0000);
      else if (c < 4)  push_exp($sformatf("midrst_c%0d", c), 4'b0010, 2'd1, 4'b1010);
      else             push_exp("midrst_c4", 4'b0010, 2'd1, 4'b1110);
      #1;
      t = sb.pop_front(); n_tests++;
      if (obs !== t.v) begin n_fail++; $display("FAIL %s: got %b expected %b", t.nm, obs, t.v); end
    end
    #1;
    Reset = 1'b0;
    push_exp("midrst_async_clear", 4'b0000, 2'd0, 4'b0000);
    #1;
    t = sb.pop_front(); n_tests++;
    if (obs !== t.v) begin n_fail++; $display("FAIL %s: got %b expected %b", t.nm, obs, t.v); end
    Req = 4'b0011; Lock = '0; BitVal = '0;
    step();
    n_tests++;
    if (flag !== 1'b0) begin n_fail++; $display("FAIL midrst_flag_kept: got %b expected 0", flag); end
    Reset = 1'b1;
    push_exp("midrst_restart_ptr0", 4'b0001, 2'd0, 4'b1010);
    step();
    t = sb.pop_front(); n_tests++;
    if (obs !== t.v) begin n_fail++; $display("FAIL %s: got %b expected %b", t.nm, obs, t.v); end
    Req = '0;
  endtask

  task automatic test_drop_req();
    exp_t t;
    logic [3:0] eg [0:2];
    logic [1:0] ei [0:2];
    logic [3:0] ef [0:2];
    eg = '{4'b0000, 4'b0010, 4'b1000};
    ei = '{2'd0, 2'd1, 2'd3};
    ef = '{4'b0000, 4'b0010, 4'b1110};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      Req    = (c == 0) ? 4'b0010 : 4'b1000;
      Lock   = '0;
      BitVal = (c == 0) ? 4'b0000 : 4'b1111;
      push_exp($sformatf("drop_c%0d", c), eg[c], ei[c], ef[c]);
      #1;
      t = sb.pop_front(); n_tests++;
      if (obs !== t.v) begin n_fail++; $display("FAIL %s: got %b expected %b", t.nm, obs, t.v); end
    end
    Req = '0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_hold_expire();
    test_reset_mid_lock();
    test_drop_req();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
